// File: rtl/fetch_controller_pkg.sv
// Purpose : shared constants for the instruction fetch controller.
// Latency : n/a (definitions only).
// Backpressure: n/a.
package fetch_controller_pkg;

    // Controller states
    localparam logic [1:0] ST_BOOT   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;
    localparam logic [1:0] ST_FAULT  = 2'd3;

    // Instruction lengths in bytes
    localparam logic [31:0] C_LEN = 32'd2;
    localparam logic [31:0] I_LEN = 32'd4;

    // The first fetched byte sits in [31:24]; its two low bits sit at [25:24].
    // Any value other than 2'b11 there marks a 16-bit compressed instruction.
    localparam int C_DET_HI = 25;
    localparam int C_DET_LO = 24;

    function automatic logic is_compressed(input logic [31:0] word);
        return (word[C_DET_HI:C_DET_LO] != 2'b11);
    endfunction

endpackage

// File: rtl/fetch_len_decode.sv
// Purpose : classify a fetched word as 16/32-bit and left-align the instruction.
// Latency : combinational.
// Backpressure: none; pure function of the memory word.
// Ports   : rdata (memory word, first byte in [31:24]) -> is_c, inst.
import fetch_controller_pkg::*;

module fetch_len_decode (
    input  logic [31:0] rdata,
    output logic        is_c,
    output logic [31:0] inst
);

    always_comb begin
        is_c = is_compressed(rdata);
        // Compressed form keeps its halfword in the upper bits, lower bits zero
        inst = is_c ? {rdata[31:16], 16'h0000} : rdata;
    end

endmodule

// File: rtl/fetch_controller.sv
// Purpose : sequential instruction fetch with redirect, halt and misalignment fault.
// Latency : memory word arrives one cycle after mem_addr; zero-bubble redirect.
// Backpressure: inst_ready low re-reads pc_q so the presented instruction holds.
// Ports   : clk/rst_n; mem_addr/mem_rdata to instruction memory;
//           inst_valid/inst_ready/inst/inst_pc/inst_is_c to decode;
//           redirect_valid/redirect_pc/halt control; fetch_fault/fetch_count status.
import fetch_controller_pkg::*;

module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_is_c,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    logic [31:0] pc_q;
    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic        fault_q;
    logic [31:0] count_q;

    logic        redirect_take;
    logic        redirect_bad;
    logic        accept;
    logic [31:0] next_seq;

    fetch_len_decode u_len_decode (
        .rdata (mem_rdata),
        .is_c  (inst_is_c),
        .inst  (inst)
    );

    assign inst_valid  = (state_q == ST_RUN);
    assign inst_pc     = pc_q;
    assign fetch_fault = fault_q;
    assign fetch_count = count_q;

    // A redirect is honoured in every state except FAULT. An odd target is
    // not loaded; it only raises the fault and leaves pc_q where it was.
    assign redirect_take = redirect_valid && (state_q != ST_FAULT);
    assign redirect_bad  = redirect_take && redirect_pc[0];

    // The instruction on the bus is squashed by a same-cycle redirect.
    assign accept   = inst_valid && inst_ready && !redirect_take;
    assign next_seq = pc_q + (inst_is_c ? C_LEN : I_LEN);

    always_comb begin
        if (!rst_n) begin
            mem_addr = RESET_PC;
        end else if (redirect_take && !redirect_pc[0]) begin
            mem_addr = redirect_pc;
        end else if (accept) begin
            mem_addr = next_seq;
        end else begin
            mem_addr = pc_q;
        end
    end

    // Halt wins over an aligned redirect for the state; the redirect still
    // loads pc_q through mem_addr, so fetch resumes at the target later.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:   state_d = halt ? ST_HALTED : ST_RUN;
            ST_RUN:    if (halt)  state_d = ST_HALTED;
            ST_HALTED: if (!halt) state_d = ST_BOOT;
            default:   state_d = ST_FAULT;
        endcase
        if (redirect_bad) begin
            state_d = ST_FAULT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            state_q <= ST_BOOT;
            fault_q <= 1'b0;
            count_q <= 32'd0;
        end else begin
            pc_q    <= mem_addr;
            state_q <= state_d;
            if (redirect_bad) begin
                fault_q <= 1'b1;
            end
            if (accept) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Purpose : self-checking bench for fetch_controller with a byte-addressed memory model.
// Latency : memory model answers one cycle after mem_addr.
// Backpressure: bench drives inst_ready directly.
module tb_fetch_controller;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_is_c;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        is_c;
    } exp_t;

    exp_t sb[$];

    logic [7:0] mem [0:1023];

    fetch_controller #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_is_c      (inst_is_c),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .fetch_fault    (fetch_fault),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rd(input logic [31:0] a);
        logic [9:0] b;
        b = a[9:0];
        return {mem[b], mem[b + 10'd1], mem[b + 10'd2], mem[b + 10'd3]};
    endfunction

    // Memory returns the word one cycle after the address is presented
    always @(posedge clk) mem_rdata <= rd(mem_addr);

    // Every aligned word is a 32-bit op: first byte {addr[7:2],2'b11}, rest addr[7:0]
    task automatic fill_default;
        for (int a = 0; a < 1024; a++) begin
            logic [9:0] av;
            av = a[9:0];
            mem[a] = (av[1:0] == 2'b00) ? {av[7:2], 2'b11} : av[7:0];
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] word, input logic c);
        exp_t e;
        e.pc = pc;
        e.inst = word;
        e.is_c = c;
        sb.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the first RUN cycle (inst_pc = RESET_PC)
    task automatic do_reset;
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        halt = 1'b0;
        inst_ready = 1'b1;
        tick;
        tick;
        #1;
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_fetch_count", fetch_count, 32'd0);
        chk("rst_fetch_fault", {31'b0, fetch_fault}, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("boot_inst_valid", {31'b0, inst_valid}, 32'd0);
        tick;
        chk("run_first_valid", {31'b0, inst_valid}, 32'd1);
        chk("run_first_pc", inst_pc, 32'h0);
    endtask

    task automatic end_phase(input string name, input logic [31:0] cnt);
        inst_ready = 1'b0;
        #1;
        chk({name, "_count"}, fetch_count, cnt);
        chk({name, "_sb_empty"}, sb.size(), 32'd0);
    endtask

    // Scoreboard monitor: every accepted instruction must match the next expectation
    always @(negedge clk) begin
        if (rst_n && inst_valid && inst_ready && !redirect_valid) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL accept_unexpected: got pc=%h inst=%h required no instruction",
                         inst_pc, inst);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (inst_pc !== e.pc || inst !== e.inst || inst_is_c !== e.is_c) begin
                    failures++;
                    $display("FAIL accept_match: got pc=%h inst=%h c=%b required pc=%h inst=%h c=%b",
                             inst_pc, inst, inst_is_c, e.pc, e.inst, e.is_c);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        inst_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        halt = 1'b0;

        // Sequential 32-bit stream with a 3-cycle stall at pc 8
        fill_default();
        push(32'h0,  32'h03010203, 1'b0);
        push(32'h4,  32'h07050607, 1'b0);
        push(32'h8,  32'h0B090A0B, 1'b0);
        push(32'hC,  32'h0F0D0E0F, 1'b0);
        push(32'h10, 32'h13111213, 1'b0);
        do_reset();
        tick;
        chk("seq_pc4", inst_pc, 32'h4);
        tick;
        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_pc", inst_pc, 32'h8);
            chk("stall_addr", mem_addr, 32'h8);
            chk("stall_count", fetch_count, 32'd2);
            chk("stall_inst", inst, 32'h0B090A0B);
            tick;
        end
        inst_ready = 1'b1;
        tick;
        chk("after_stall_pc", inst_pc, 32'hC);
        tick;
        tick;
        end_phase("seq", 32'd5);

        // Mixed 16/32-bit stream
        fill_default();
        mem[0] = 8'h01; mem[1] = 8'hA5;
        mem[2] = 8'h13; mem[3] = 8'h22; mem[4] = 8'h33; mem[5] = 8'h44;
        mem[6] = 8'h02; mem[7] = 8'h5A;
        push(32'h0, 32'h01A50000, 1'b1);
        push(32'h2, 32'h13223344, 1'b0);
        push(32'h6, 32'h025A0000, 1'b1);
        push(32'h8, 32'h0B090A0B, 1'b0);
        do_reset();
        tick;
        tick;
        tick;
        tick;
        chk("mixed_next_pc", inst_pc, 32'hC);
        end_phase("mixed", 32'd4);

        // Aligned redirect while pc 8 is on the bus
        fill_default();
        push(32'h0,   32'h03010203, 1'b0);
        push(32'h4,   32'h07050607, 1'b0);
        push(32'h100, 32'h03010203, 1'b0);
        push(32'h104, 32'h07050607, 1'b0);
        do_reset();
        tick;
        tick;
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        #1;
        chk("redir_addr", mem_addr, 32'h100);
        tick;
        redirect_valid = 1'b0;
        #1;
        chk("redir_pc", inst_pc, 32'h100);
        chk("redir_valid", {31'b0, inst_valid}, 32'd1);
        chk("redir_count", fetch_count, 32'd2);
        tick;
        tick;
        end_phase("redir", 32'd4);

        // Misaligned redirect: sticky fault, later redirects ignored, reset clears
        push(32'h0, 32'h03010203, 1'b0);
        push(32'h4, 32'h07050607, 1'b0);
        do_reset();
        tick;
        tick;
        redirect_valid = 1'b1;
        redirect_pc = 32'h101;
        #1;
        chk("fault_addr_hold", mem_addr, 32'h8);
        tick;
        redirect_valid = 1'b0;
        #1;
        chk("fault_flag", {31'b0, fetch_fault}, 32'd1);
        chk("fault_valid", {31'b0, inst_valid}, 32'd0);
        chk("fault_count", fetch_count, 32'd2);
        chk("fault_pc_hold", inst_pc, 32'h8);
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        #1;
        chk("fault_redir_ignored", mem_addr, 32'h8);
        tick;
        tick;
        redirect_valid = 1'b0;
        #1;
        chk("fault_still_invalid", {31'b0, inst_valid}, 32'd0);
        chk("fault_still_set", {31'b0, fetch_fault}, 32'd1);
        chk("fault_pc_after", inst_pc, 32'h8);
        rst_n = 1'b0;
        #1;
        chk("fault_rst_addr", mem_addr, 32'h0);
        tick;
        chk("fault_cleared", {31'b0, fetch_fault}, 32'd0);
        chk("fault_count_cleared", fetch_count, 32'd0);
        chk("fault_sb_empty", sb.size(), 32'd0);

        // Halt with simultaneous redirect, halt released two cycles later
        fill_default();
        push(32'h0,  32'h03010203, 1'b0);
        push(32'h4,  32'h07050607, 1'b0);
        push(32'h40, 32'h43414243, 1'b0);
        push(32'h44, 32'h47454647, 1'b0);
        do_reset();
        tick;
        tick;
        halt = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        #1;
        chk("halt_redir_addr", mem_addr, 32'h40);
        tick;
        redirect_valid = 1'b0;
        #1;
        chk("halted_valid_1", {31'b0, inst_valid}, 32'd0);
        tick;
        halt = 1'b0;
        #1;
        chk("halted_valid_2", {31'b0, inst_valid}, 32'd0);
        tick;
        chk("boot_bubble_valid", {31'b0, inst_valid}, 32'd0);
        chk("boot_bubble_pc", inst_pc, 32'h40);
        tick;
        chk("resume_valid", {31'b0, inst_valid}, 32'd1);
        chk("resume_pc", inst_pc, 32'h40);
        tick;
        tick;
        end_phase("halt", 32'd4);

        // Address wrap at the top of the 32-bit space
        push(32'h0,          32'h03010203, 1'b0);
        push(32'hFFFF_FFFC,  32'hFFFDFEFF, 1'b0);
        push(32'h0,          32'h03010203, 1'b0);
        do_reset();
        tick;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick;
        redirect_valid = 1'b0;
        #1;
        chk("wrap_top_pc", inst_pc, 32'hFFFF_FFFC);
        tick;
        chk("wrap_zero_pc", inst_pc, 32'h0);
        tick;
        end_phase("wrap", 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 mem_addr  output  32  byte address presented to instruction memory, sampled by memory on the same edge.
REQ-005 mem_rdata  input  32  instruction word returned one cycle after mem_addr; first byte at [31:24].
REQ-006 inst_valid  output  1  inst/inst_pc/inst_is_c hold a valid fetched instruction.
REQ-007 inst_ready  input  1  decode accepts the instruction this cycle.
REQ-008 inst  output  32  instruction; 16-bit form in [31:16], [15:0] zero.
REQ-009 inst_pc  output  32  byte address of inst.
REQ-010 inst_is_c  output  1  inst is 16-bit compressed.
REQ-011 redirect_valid  input  1  branch/jump/trap redirect request.
REQ-012 redirect_pc  input  32  redirect target.
REQ-013 halt  input  1  level request to stop fetching.
REQ-014 fetch_fault  output  1  sticky misaligned-redirect flag.
REQ-015 fetch_count  output  32  count of accepted instructions.

Function
REQ-016 Registers: pc_q (address of read in flight), state in {BOOT, RUN, HALTED, FAULT}, fetch_fault, fetch_count.
REQ-017 inst_is_c = (mem_rdata[25:24] != 2'b11); inst = inst_is_c ? {mem_rdata[31:16],16'h0000} : mem_rdata.
REQ-018 inst_valid = (state == RUN); inst_pc = pc_q; accept = inst_valid && inst_ready.
REQ-019 mem_addr priority: rst_n low -> RESET_PC; redirect_valid (state != FAULT) -> redirect_pc; accept -> pc_q + (inst_is_c ? 2 : 4); else pc_q.
REQ-020 Every edge: pc_q <= mem_addr; stall (inst_valid, !inst_ready) re-reads pc_q, so outputs stay stable.
REQ-021 Next-address addition is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-022 Transitions: BOOT->RUN if !halt, else HALTED; RUN->HALTED on halt; HALTED->BOOT when halt drops; FAULT terminal until reset.
REQ-023 halt takes priority over redirect for state; a simultaneous redirect still loads pc_q, and fetch resumes from redirect_pc.
REQ-024 Redirect with redirect_pc[0]==1: fetch_fault<=1, state<=FAULT, pc_q unchanged; in FAULT inst_valid=0 and redirect is ignored.
REQ-025 Redirect in RUN: current instruction is not accepted regardless of inst_ready, and fetch_count does not increment; next cycle inst_pc = redirect_pc, inst_valid=1 unless halt.
REQ-026 fetch_count increments by 1 per accept and wraps from 32'hFFFF_FFFF to 0.
REQ-027 Throughput: one instruction per cycle while inst_ready=1 with no redirect; the redirect penalty is zero bubbles.

Reset
REQ-028 While rst_n=0: pc_q=RESET_PC, state=BOOT, fetch_fault=0, fetch_count=0, inst_valid=0, mem_addr=RESET_PC.
REQ-029 First cycle after release: BOOT (inst_valid=0); second cycle: inst_valid=1, inst_pc=RESET_PC.
REQ-030 Reset asserted mid-stall or mid-redirect discards all state within the same edge.

Structure
REQ-031 Shared package holds the state enumeration, C_LEN (2) and I_LEN (4) constants, and the compressed-detect bit positions.
REQ-032 One sub-module, fetch_len_decode, computes inst_is_c and the aligned inst from mem_rdata.

Verification
REQ-033 Reset release, RESET_PC=0, memory all 32-bit ops, inst_ready=1 -> inst_pc 0,4,8,12 on consecutive cycles from cycle 2.
REQ-034 Mixed stream: 16-bit at 0, 32-bit at 2, 16-bit at 6 -> inst_pc 0,2,6,8; inst_is_c 1,0,1.
REQ-035 inst_ready=0 for 3 cycles at inst_pc=8 -> inst/inst_pc held, mem_addr=8, fetch_count frozen; then advances to 12.
REQ-036 redirect_valid with redirect_pc=32'h100 while inst_pc=8 -> next cycle inst_pc=32'h100, no instruction at 8 counted.
REQ-037 redirect_pc=32'h101 -> fetch_fault=1, inst_valid=0 permanently; later redirects ignored; rst_n low clears.
REQ-038 halt with simultaneous redirect to 32'h40, halt released 2 cycles later -> one BOOT bubble, then inst_pc=32'h40.
